// File: rtl/seg7_pkg.sv
// Shared seven-segment types and glyph constants.
// Segments are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h7F;
  localparam seg7_t SEG_DASH  = 7'h3F;

  localparam seg7_t GLYPH_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, SEG_DASH, SEG_DASH,
    SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH
  };

endpackage

// File: rtl/seg7_decode.sv
// 4-bit code to active-low glyph.
// Codes above 9 render as a dash.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output seg7_t      seg
);

  assign seg = GLYPH_TAB[code];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode seven-segment scanner
// with tear-free snapshot, lz blanking and guard.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int PRESCALE = 50000,
  parameter int GUARD    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] din,
  input  logic                  load,
  input  logic                  lz_en,
  input  logic [N_DIGITS-1:0]   dp_mask,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW =
    (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST =
    IW'(N_DIGITS - 1);

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [4*N_DIGITS-1:0] shadow;
  logic [4*N_DIGITS-1:0] disp;
  logic                  tick;
  logic                  frame_end;
  logic                  guarded;
  logic                  upper_zero;
  logic                  blank;
  logic [3:0]            cur;
  seg7_t                 glyph;

  assign tick      = (cnt == CNT_LAST);
  assign frame_end = tick && (idx == IDX_LAST);
  assign guarded   = int'(cnt) < GUARD;
  assign cur       = disp[{idx, 2'b00} +: 4];

  // Prescaler and slot index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Shadow capture; display swaps only at frame end
  // using the pre-edge shadow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      disp   <= '0;
    end else begin
      if (load)      shadow <= din;
      if (frame_end) disp   <= shadow;
    end
  end

  // All digits above the current slot are zero.
  always_comb begin
    upper_zero = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (i > int'(idx) && disp[4*i +: 4] != 4'h0)
        upper_zero = 1'b0;
    end
  end

  assign blank = lz_en && (cur == 4'h0) &&
                 (idx != '0) && upper_zero;

  seg7_decode u_dec (
    .code (cur),
    .seg  (glyph)
  );

  // Registered outputs; dark during the guard window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else if (guarded) begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= ~(N_DIGITS'(1) << idx);
      seg <= blank ? SEG_BLANK : glyph;
      dp  <= ~dp_mask[idx];
    end
  end

endmodule
